// File: rtl/disparity_scan_ctrl_if.sv
// disparity_scan_ctrl_if: start/status, window-memory read port and result
// handshake of the disparity scan controller. The controller uses the master
// modport; the memories/writer side (or a bench) uses the slave modport.
interface disparity_scan_ctrl_if #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 40,
    parameter int MAX_DISP = 16
);
    localparam int HW = $clog2(IMG_W) + 1;
    localparam int VW = $clog2(IMG_H) + 1;
    localparam int DW = $clog2(MAX_DISP + 1);

    logic          start;
    logic          busy;
    logic          done;
    logic [HW-1:0] left_hcount;
    logic [VW-1:0] left_vcount;
    logic [HW-1:0] right_hcount;
    logic [VW-1:0] right_vcount;
    logic          rd_valid;
    logic [47:0]   left_win;
    logic [47:0]   right_win;
    logic          disp_valid;
    logic          disp_ready;
    logic [HW-1:0] disp_h;
    logic [VW-1:0] disp_v;
    logic [DW-1:0] disp;
    logic [10:0]   disp_cost;

    modport master (
        input  start, left_win, right_win, disp_ready,
        output busy, done, left_hcount, left_vcount, right_hcount, right_vcount,
               rd_valid, disp_valid, disp_h, disp_v, disp, disp_cost
    );

    modport slave (
        output start, left_win, right_win, disp_ready,
        input  busy, done, left_hcount, left_vcount, right_hcount, right_vcount,
               rd_valid, disp_valid, disp_h, disp_v, disp, disp_cost
    );
endinterface

// File: rtl/disparity_scan_ctrl.sv
// disparity_scan_ctrl: per left pixel, sweeps candidate disparities
// d = 0..min(MAX_DISP,h), reads left (h,v) and right (h-d,v) windows, sums
// absolute byte differences (SAD) and keeps the first strict minimum, then
// hands out one result per pixel in raster order.
// Optional feature macro: DISP_THRESH_EN -- when defined, a pixel whose best
// SAD exceeds COST_THRESH reports disp = all ones (cost still reported).
// Assumes MAX_DISP < IMG_W so disparity counts fit the column width.
module disparity_scan_ctrl #(
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 40,
    parameter int MAX_DISP    = 16,
    parameter int RD_LAT      = 2,
    parameter int COST_THRESH = 300
) (
    input  logic                  clk_100mhz,
    input  logic                  sys_rst,
    disparity_scan_ctrl_if.master bus
);
    localparam int HW = $clog2(IMG_W) + 1;
    localparam int VW = $clog2(IMG_H) + 1;
    localparam int DW = $clog2(MAX_DISP + 1);
    localparam int CW = $clog2(RD_LAT) + 1;

`ifdef DISP_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [HW-1:0] lh_q, lh_d;
    logic [VW-1:0] lv_q, lv_d;
    logic [HW-1:0] rh_q, rh_d;
    logic [VW-1:0] rv_q, rv_d;
    logic          disp_valid_q, disp_valid_d;
    logic [HW-1:0] disp_h_q, disp_h_d;
    logic [VW-1:0] disp_v_q, disp_v_d;
    logic [DW-1:0] disp_val_q, disp_val_d;
    logic [10:0]   disp_cost_q, disp_cost_d;
    logic [10:0]   min_cost_q, min_cost_d;
    logic [DW-1:0] best_disp_q, best_disp_d;

    // Read tags: each issued address carries {valid, d} down an RD_LAT-deep
    // shift register so it lines up with the window data it produced.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
        logic          stg_valid_q;
        logic [DW-1:0] stg_disp_q;
        logic          stg_valid_d;
        logic [DW-1:0] stg_disp_d;
        if (gi == 0) begin : g_src
            assign stg_valid_d = rd_valid_q;
            assign stg_disp_d  = dcnt_q;
        end else begin : g_shift
            assign stg_valid_d = g_pipe[gi-1].stg_valid_q;
            assign stg_disp_d  = g_pipe[gi-1].stg_disp_q;
        end
        // Advance one tag stage; reset discards reads in flight.
        always_ff @(posedge clk_100mhz) begin
            if (!sys_rst) begin
                stg_valid_q <= 1'b0;
                stg_disp_q  <= '0;
            end else begin
                stg_valid_q <= stg_valid_d;
                stg_disp_q  <= stg_disp_d;
            end
        end
    end

    logic          cand_valid;
    logic [DW-1:0] cand_disp;
    assign cand_valid = g_pipe[RD_LAT-1].stg_valid_q;
    assign cand_disp  = g_pipe[RD_LAT-1].stg_disp_q;

    // Per-byte absolute differences of the returning windows.
    logic [47:0] absd_flat;
    for (genvar gi = 0; gi < 6; gi++) begin : g_absd
        logic [7:0] l_byte;
        logic [7:0] r_byte;
        assign l_byte = bus.left_win[gi*8 +: 8];
        assign r_byte = bus.right_win[gi*8 +: 8];
        assign absd_flat[gi*8 +: 8] = (l_byte > r_byte) ? (l_byte - r_byte) : (r_byte - l_byte);
    end

    logic [10:0] sad;
    // Sum the six byte differences; 6*255 fits in 11 bits, no saturation.
    always_comb begin
        sad = '0;
        for (int i = 0; i < 6; i++) begin
            sad = sad + 11'(absd_flat[i*8 +: 8]);
        end
    end

    logic          take;
    logic [10:0]   min_cost_next;
    logic [DW-1:0] best_disp_next;
    logic          reject;
    // Running minimum: d==0 is always the first candidate of a sweep and
    // reloads the minimum; later ones replace it only when strictly cheaper.
    always_comb begin
        take           = cand_valid && ((cand_disp == '0) || (sad < min_cost_q));
        min_cost_next  = take ? sad : min_cost_q;
        best_disp_next = take ? cand_disp : best_disp_q;
        reject         = THRESH_EN && (min_cost_next > 11'(COST_THRESH));
    end

    logic [HW-1:0] dmax;
    logic [DW-1:0] dcnt_inc;
    logic [HW-1:0] h_inc;
    logic [VW-1:0] v_inc;
    logic          last_pix;
    // Next-state and next-output logic of the scan sequencer.
    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        dcnt_d       = dcnt_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_valid_d   = rd_valid_q;
        lh_d         = lh_q;
        lv_d         = lv_q;
        rh_d         = rh_q;
        rv_d         = rv_q;
        disp_valid_d = disp_valid_q;
        disp_h_d     = disp_h_q;
        disp_v_d     = disp_v_q;
        disp_val_d   = disp_val_q;
        disp_cost_d  = disp_cost_q;
        min_cost_d   = min_cost_next;
        best_disp_d  = best_disp_next;

        dmax     = (h_q < HW'(MAX_DISP)) ? h_q : HW'(MAX_DISP);
        dcnt_inc = dcnt_q + 1'b1;
        last_pix = (h_q == HW'(IMG_W - 1)) && (v_q == VW'(IMG_H - 1));
        if (h_q == HW'(IMG_W - 1)) begin
            h_inc = '0;
            v_inc = v_q + 1'b1;
        end else begin
            h_inc = h_q + 1'b1;
            v_inc = v_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_SWEEP;
                    h_d        = '0;
                    v_d        = '0;
                    dcnt_d     = '0;
                    busy_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    lh_d       = '0;
                    lv_d       = '0;
                    rh_d       = '0;
                    rv_d       = '0;
                end
            end
            S_SWEEP: begin
                if (HW'(dcnt_q) == dmax) begin
                    state_d    = S_DRAIN;
                    cnt_d      = '0;
                    rd_valid_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_inc;
                    rh_d   = h_q - HW'(dcnt_inc);
                end
            end
            S_DRAIN: begin
                // Last DRAIN cycle sees the final candidate; publish result.
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d      = S_OUT;
                    disp_valid_d = 1'b1;
                    disp_h_d     = h_q;
                    disp_v_d     = v_q;
                    disp_cost_d  = min_cost_next;
                    disp_val_d   = reject ? '1 : best_disp_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.disp_ready) begin
                    disp_valid_d = 1'b0;
                    if (last_pix) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_SWEEP;
                        h_d        = h_inc;
                        v_d        = v_inc;
                        dcnt_d     = '0;
                        rd_valid_d = 1'b1;
                        lh_d       = h_inc;
                        lv_d       = v_inc;
                        rh_d       = h_inc;
                        rv_d       = v_inc;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk_100mhz) begin
        if (!sys_rst) begin
            state_q      <= S_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            dcnt_q       <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            lh_q         <= '0;
            lv_q         <= '0;
            rh_q         <= '0;
            rv_q         <= '0;
            disp_valid_q <= 1'b0;
            disp_h_q     <= '0;
            disp_v_q     <= '0;
            disp_val_q   <= '0;
            disp_cost_q  <= '0;
            min_cost_q   <= '0;
            best_disp_q  <= '0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            dcnt_q       <= dcnt_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
            lh_q         <= lh_d;
            lv_q         <= lv_d;
            rh_q         <= rh_d;
            rv_q         <= rv_d;
            disp_valid_q <= disp_valid_d;
            disp_h_q     <= disp_h_d;
            disp_v_q     <= disp_v_d;
            disp_val_q   <= disp_val_d;
            disp_cost_q  <= disp_cost_d;
            min_cost_q   <= min_cost_d;
            best_disp_q  <= best_disp_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.left_hcount  = lh_q;
    assign bus.left_vcount  = lv_q;
    assign bus.right_hcount = rh_q;
    assign bus.right_vcount = rv_q;
    assign bus.disp_valid   = disp_valid_q;
    assign bus.disp_h       = disp_h_q;
    assign bus.disp_v       = disp_v_q;
    assign bus.disp         = disp_val_q;
    assign bus.disp_cost    = disp_cost_q;
endmodule

// File: tb/tb_disparity_scan_ctrl.sv
// tb_disparity_scan_ctrl: directed frames over a reduced 24x4 image with
// window memories of latency 2; results and read addresses are checked
// against a per-pixel argmin model computed straight from the images.
module tb_disparity_scan_ctrl;
    localparam int W  = 24;
    localparam int H  = 4;
    localparam int MD = 16;
    localparam int RL = 2;
    localparam int CT = 300;
    localparam int DW = $clog2(MD + 1);

    logic clk_100mhz = 1'b0;
    logic sys_rst    = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    logic [47:0] limg [H][W];
    logic [47:0] rimg [H][W];
    logic [47:0] lpipe [RL];
    logic [47:0] rpipe [RL];

    typedef struct {int h; int v; int d; int c;} res_t;
    typedef struct {int lh; int lv; int rh; int rv;} rd_t;
    res_t res_q[$];
    rd_t  rd_q[$];

    logic clr_req      = 1'b0;
    int   cyc          = 0;
    int   last_hs_cyc  = 0;
    int   done_cnt     = 0;
    int   done_cyc     = 0;
    int   overlap_cnt  = 0;
    logic busy_at_done = 1'b0;

    always #5 clk_100mhz = ~clk_100mhz;

    disparity_scan_ctrl_if #(.IMG_W(W), .IMG_H(H), .MAX_DISP(MD)) bus ();

    disparity_scan_ctrl #(
        .IMG_W(W), .IMG_H(H), .MAX_DISP(MD), .RD_LAT(RL), .COST_THRESH(CT)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .sys_rst   (sys_rst),
        .bus       (bus)
    );

    // window memories with RL cycles of read latency
    always @(posedge clk_100mhz) begin
        lpipe[0] <= bus.rd_valid ? limg[int'(bus.left_vcount)][int'(bus.left_hcount)] : 48'h0;
        rpipe[0] <= bus.rd_valid ? rimg[int'(bus.right_vcount)][int'(bus.right_hcount)] : 48'h0;
        for (int i = 1; i < RL; i++) begin
            lpipe[i] <= lpipe[i-1];
            rpipe[i] <= rpipe[i-1];
        end
    end
    assign bus.left_win  = lpipe[RL-1];
    assign bus.right_win = rpipe[RL-1];

    // monitor: logs reads, result handshakes and done pulses
    always @(negedge clk_100mhz) begin
        cyc <= cyc + 1;
        if (clr_req) begin
            res_q.delete();
            rd_q.delete();
            done_cnt    <= 0;
            overlap_cnt <= 0;
            last_hs_cyc <= 0;
            done_cyc    <= 0;
        end else begin
            if (bus.disp_valid && bus.disp_ready) begin
                res_q.push_back('{int'(bus.disp_h), int'(bus.disp_v), int'(bus.disp), int'(bus.disp_cost)});
                last_hs_cyc <= cyc;
                $display("pixel h=%0d v=%0d disp=%0d cost=%0d", bus.disp_h, bus.disp_v, bus.disp, bus.disp_cost);
            end
            if (bus.rd_valid)
                rd_q.push_back('{int'(bus.left_hcount), int'(bus.left_vcount), int'(bus.right_hcount), int'(bus.right_vcount)});
            if (bus.rd_valid && bus.disp_valid)
                overlap_cnt <= overlap_cnt + 1;
            if (bus.done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                busy_at_done <= bus.busy;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.done, bus.left_hcount, bus.left_vcount, bus.right_hcount,
                    bus.right_vcount, bus.rd_valid, bus.disp_valid, bus.disp_h, bus.disp_v,
                    bus.disp, bus.disp_cost});
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    // best disparity of pixel (h,v): smallest d reaching the minimum SAD
    function automatic void model_pixel(input int h, input int v, output int ed, output int ec);
        int best;
        int bd;
        int dmax;
        int c;
        int a;
        int b;
        best = -1;
        bd   = 0;
        dmax = (h < MD) ? h : MD;
        for (int d = 0; d <= dmax; d++) begin
            c = 0;
            for (int i = 0; i < 6; i++) begin
                a = int'(limg[v][h][8*i +: 8]);
                b = int'(rimg[v][h-d][8*i +: 8]);
                c += (a > b) ? (a - b) : (b - a);
            end
            if (best < 0 || c < best) begin
                best = c;
                bd   = d;
            end
        end
`ifdef DISP_THRESH_EN
        if (best > CT) bd = (1 << DW) - 1;
`endif
        ed = bd;
        ec = best;
    endfunction

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        @(negedge clk_100mhz);
        tick();
        clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rand_ready) bus.disp_ready = ($urandom_range(0, 3) != 0);
            bus.start = (n == 40);
            tick();
            n++;
        end
        bus.start      = 1'b0;
        bus.disp_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag);
        int n;
        int ed;
        int ec;
        int ri;
        int h;
        int v;
        int dmax;
        chk({tag, "_npix"}, res_q.size(), W * H);
        n = (res_q.size() < W * H) ? res_q.size() : W * H;
        for (int p = 0; p < n; p++) begin
            model_pixel(p % W, p / W, ed, ec);
            chk($sformatf("%s_pix%0d_hv", tag, p), pack4(0, 0, res_q[p].h, res_q[p].v), pack4(0, 0, p % W, p / W));
            chk($sformatf("%s_pix%0d_disp", tag, p), res_q[p].d, ed);
            chk($sformatf("%s_pix%0d_cost", tag, p), res_q[p].c, ec);
        end
        ri = 0;
        for (int p = 0; p < W * H; p++) begin
            h    = p % W;
            v    = p / W;
            dmax = (h < MD) ? h : MD;
            for (int d = 0; d <= dmax; d++) begin
                if (ri < rd_q.size())
                    chk($sformatf("%s_rd%0d", tag, ri),
                        pack4(rd_q[ri].lh, rd_q[ri].lv, rd_q[ri].rh, rd_q[ri].rv), pack4(h, v, h - d, v));
                ri++;
            end
        end
        chk({tag, "_nreads"}, rd_q.size(), ri);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_timing"}, done_cyc, last_hs_cyc + 1);
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        chk({tag, "_rd_during_out"}, overlap_cnt, 0);
        chk({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        int n;
        int ed;
        int ec;
        int p;
        bus.start      = 1'b0;
        bus.disp_ready = 1'b1;
        sys_rst        = 1'b0;

        // reset state
        repeat (3) tick();
        @(negedge clk_100mhz);
        chk("reset_outputs", outs(), 0);
        tick();
        sys_rst = 1'b1;
        tick();
        chk("idle_after_reset", outs(), 0);

        // flat image: all ties, smallest d wins
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++) begin
                limg[v][h] = 48'h808080808080;
                rimg[v][h] = 48'h808080808080;
            end
        clear_mon();
        pulse_start();
        wait_done(1'b0, 20000);
        check_frame("tie");
        if (res_q.size() == W * H)
            chk("tie_last_disp_cost", pack4(0, 0, res_q[W*H-1].d, res_q[W*H-1].c), 0);

        // textured image shifted by 5, with backpressure on the first pixel
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                limg[v][h] = {16'($urandom), 32'($urandom)};
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                rimg[v][h] = (h + 5 < W) ? limg[v][h+5] : {16'($urandom), 32'($urandom)};
        clear_mon();
        bus.disp_ready = 1'b0;
        pulse_start();
        n = 0;
        while (!bus.disp_valid && n < 200) begin
            @(negedge clk_100mhz);
            n++;
        end
        chk("bp_valid_seen", bus.disp_valid, 1);
        model_pixel(0, 0, ed, ec);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold%0d", k),
                pack4(int'(bus.disp_valid), int'(bus.rd_valid), int'(bus.disp_h), int'(bus.disp_v)),
                pack4(1, 0, 0, 0));
            chk($sformatf("bp_hold%0d_result", k), pack4(0, 0, int'(bus.disp), int'(bus.disp_cost)), pack4(0, 0, ed, ec));
            @(negedge clk_100mhz);
        end
        tick();
        bus.disp_ready = 1'b1;
        @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        chk("bp_advance", pack4(int'(bus.disp_valid), int'(bus.rd_valid), int'(bus.left_hcount), int'(bus.right_hcount)),
            pack4(0, 1, 1, 1));
        tick();
        wait_done(1'b0, 20000);
        check_frame("shift");
        p = 2 * W + 20;
        if (res_q.size() > p)
            chk("shift_pix20_2", pack4(0, 0, res_q[p].d, res_q[p].c), pack4(0, 0, 5, 0));
        if (rd_q.size() > 6) begin
            chk("edge_rd0", pack4(rd_q[3].lh, 0, rd_q[3].rh, 0), pack4(2, 0, 2, 0));
            chk("edge_rd1", pack4(rd_q[4].lh, 0, rd_q[4].rh, 0), pack4(2, 0, 1, 0));
            chk("edge_rd2", pack4(rd_q[5].lh, 0, rd_q[5].rh, 0), pack4(2, 0, 0, 0));
            chk("edge_next", rd_q[6].lh, 3);
        end

        // low-contrast random images (many ties) with random backpressure
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++)
                for (int i = 0; i < 6; i++) begin
                    limg[v][h][8*i +: 8] = 8'($urandom_range(0, 3));
                    rimg[v][h][8*i +: 8] = 8'($urandom_range(0, 3));
                end
        clear_mon();
        pulse_start();
        wait_done(1'b1, 40000);
        check_frame("rand");

        // reset in the middle of a sweep, then a clean frame from (0,0)
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++) begin
                limg[v][h] = {16'($urandom), 32'($urandom)};
                rimg[v][h] = {16'($urandom), 32'($urandom)};
            end
        clear_mon();
        pulse_start();
        n = 0;
        while (!(bus.rd_valid && bus.left_hcount == 15 && bus.left_vcount == 1) && n < 5000) begin
            @(negedge clk_100mhz);
            n++;
        end
        chk("midrst_reached", n < 5000, 1);
        tick();
        sys_rst = 1'b0;
        @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        chk("midrst_outputs", outs(), 0);
        tick();
        sys_rst = 1'b1;
        tick();
        clear_mon();
        pulse_start();
        wait_done(1'b0, 20000);
        check_frame("post_rst");

`ifdef DISP_THRESH_EN
        // every byte differs by 100 -> cost 600 for every d -> invalid marker
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++) begin
                limg[v][h] = 48'h969696969696;
                rimg[v][h] = 48'h323232323232;
            end
        clear_mon();
        pulse_start();
        wait_done(1'b0, 20000);
        check_frame("thresh");
        if (res_q.size() > 7)
            chk("thresh_pix7", pack4(0, 0, res_q[7].d, res_q[7].c), pack4(0, 0, (1 << DW) - 1, 600));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
